// File: rtl/alu_selftest_sched_pkg.sv
// Shared definitions for the ALU self-test scheduler: op codes, FSM states, LFSR.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alu_selftest_sched_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

    // Op rotation applied to each operand pair.
    function automatic logic [2:0] op_of_idx(input logic [2:0] idx);
        logic [2:0] op;
        case (idx)
            3'd0:    op = ALU_AND;
            3'd1:    op = ALU_OR;
            3'd2:    op = ALU_ADD;
            3'd3:    op = ALU_SUB;
            default: op = ALU_SLT;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_selftest_sched_golden.sv
// Golden ALU reference: result and zero flag for a, b, alucont.
// Latency: combinational. Backpressure: none.
// Ports: a, b (32b operands), alucont (3b op) in; result (32b), zero out.
module alu_golden
    import alu_selftest_sched_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alucont,
    output logic [31:0] result,
    output logic        zero
);

    logic [31:0] diff;
    assign diff = a - b;

    always_comb begin
        result = 32'h0;
        case (alucont)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = diff;
            ALU_SLT: result = {31'b0, diff[31]};
            default: result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/alu_selftest_sched.sv
// Shares the ALU between the CPU and a background self-test engine; counts result mismatches.
// Latency: operand mux combinational; fault status registered one cycle after a compare.
// Backpressure: none on the CPU -- cpu_req preempts a test vector in the same cycle.
// Ports: clk, reset; test_en, cpu_req, cpu_a/b/alucont in; alu_a/b/alucont out; alu_result/zero in;
//        test_busy, burst_done, fault_count, fault_alarm, first_fail_op, first_fail_a out.
module alu_selftest_sched
    import alu_selftest_sched_pkg::*;
#(
    parameter int          IDLE_THRESH = 4,
    parameter int          NUM_VECTORS = 20,
    parameter int          FAULT_LIMIT = 1,
    parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        test_en,
    input  logic        cpu_req,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_b,
    input  logic [2:0]  cpu_alucont,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_alucont,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        test_busy,
    output logic        burst_done,
    output logic [7:0]  fault_count,
    output logic        fault_alarm,
    output logic [2:0]  first_fail_op,
    output logic [31:0] first_fail_a
);

    localparam logic [15:0] IDLE_LAST = 16'(IDLE_THRESH - 1);
    localparam logic [15:0] VEC_LAST  = 16'(NUM_VECTORS - 1);

    state_t      state;
    logic [15:0] idle_cnt;
    logic [15:0] vec_cnt;
    logic [2:0]  op_idx;
    logic [31:0] lfsr;

    logic [31:0] test_a;
    logic [31:0] test_b;
    logic [2:0]  test_op;
    logic [31:0] golden;
    logic        golden_zero;
    logic        idle_cycle;
    logic        mismatch;
    logic [7:0]  fault_inc;

    assign test_a  = lfsr;
    assign test_b  = {lfsr[15:0], lfsr[31:16]};
    assign test_op = op_of_idx(op_idx);

    // CPU wins combinationally, so a request never waits on the test engine.
    assign test_busy   = (state == ST_TEST) & ~cpu_req & test_en;
    assign alu_a       = test_busy ? test_a  : cpu_a;
    assign alu_b       = test_busy ? test_b  : cpu_b;
    assign alu_alucont = test_busy ? test_op : cpu_alucont;

    alu_golden u_golden (
        .a       (test_a),
        .b       (test_b),
        .alucont (test_op),
        .result  (golden),
        .zero    (golden_zero)
    );

    assign idle_cycle = ~cpu_req & test_en;
    assign mismatch   = test_busy & ((alu_result != golden) | (alu_zero != golden_zero));
    assign fault_inc  = (fault_count == 8'hFF) ? fault_count : fault_count + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            idle_cnt      <= 16'h0;
            vec_cnt       <= 16'h0;
            op_idx        <= 3'd0;
            lfsr          <= LFSR_SEED;
            burst_done    <= 1'b0;
            fault_count   <= 8'h0;
            fault_alarm   <= 1'b0;
            first_fail_op <= 3'b0;
            first_fail_a  <= 32'h0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (idle_cycle) begin
                        if (idle_cnt == IDLE_LAST) begin
                            state    <= ST_TEST;
                            idle_cnt <= 16'h0;
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end else begin
                        idle_cnt <= 16'h0;
                    end
                end
                ST_TEST: begin
                    if (test_busy) begin
                        // Step the LFSR only after all five ops used the current pair.
                        if (op_idx == 3'd4) begin
                            op_idx <= 3'd0;
                            lfsr   <= lfsr_next(lfsr);
                        end else begin
                            op_idx <= op_idx + 3'd1;
                        end
                        if (vec_cnt == VEC_LAST) begin
                            state      <= ST_IDLE;
                            vec_cnt    <= 16'h0;
                            idle_cnt   <= 16'h0;
                            burst_done <= 1'b1;
                        end else begin
                            vec_cnt <= vec_cnt + 16'd1;
                        end
                    end else begin
                        // Preempted: vector position is kept so the burst resumes here.
                        state    <= ST_IDLE;
                        idle_cnt <= 16'h0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (mismatch) begin
                fault_count <= fault_inc;
                if (fault_count == 8'h0) begin
                    first_fail_op <= test_op;
                    first_fail_a  <= test_a;
                end
                if (int'(fault_inc) >= FAULT_LIMIT) begin
                    fault_alarm <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_selftest_sched.sv
// Self-checking bench for alu_selftest_sched with a behavioural ALU and schedule model.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_alu_selftest_sched;

    localparam int IDLE_THRESH = 4;
    localparam int NUM_VECTORS = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        test_en;
    logic        cpu_req;
    logic [31:0] cpu_a;
    logic [31:0] cpu_b;
    logic [2:0]  cpu_alucont;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_alucont;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        test_busy;
    logic        burst_done;
    logic [7:0]  fault_count;
    logic        fault_alarm;
    logic [2:0]  first_fail_op;
    logic [31:0] first_fail_a;

    logic [31:0] gold_res;
    logic        gold_zero;

    logic        stuck1  = 1'b0;
    logic        corrupt = 1'b0;
    logic [31:0] bench_r;

    int errors = 0;
    int checks = 0;
    int g;

    always #5 clk = ~clk;

    alu_selftest_sched #(
        .IDLE_THRESH (IDLE_THRESH),
        .NUM_VECTORS (NUM_VECTORS),
        .FAULT_LIMIT (1),
        .LFSR_SEED   (32'h0000_0001)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .test_en       (test_en),
        .cpu_req       (cpu_req),
        .cpu_a         (cpu_a),
        .cpu_b         (cpu_b),
        .cpu_alucont   (cpu_alucont),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_alucont   (alu_alucont),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .test_busy     (test_busy),
        .burst_done    (burst_done),
        .fault_count   (fault_count),
        .fault_alarm   (fault_alarm),
        .first_fail_op (first_fail_op),
        .first_fail_a  (first_fail_a)
    );

    // Standalone golden instance, checked against hand-derived results.
    alu_golden u_gold (
        .a       (alu_a),
        .b       (alu_b),
        .alucont (alu_alucont),
        .result  (gold_res),
        .zero    (gold_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] d;
        d = a - b;
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return d;
            3'b111:  return {31'b0, d[31]};
            default: return 32'h0;
        endcase
    endfunction

    // LFSR value seen by the n-th operand pair since reset.
    function automatic logic [31:0] lfsr_at(input int n);
        logic [31:0] s;
        s = 32'h0000_0001;
        for (int i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        return s;
    endfunction

    function automatic logic [2:0] op_at(input int k);
        case (k % 5)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            3:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] swap_half(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

    // Behavioural ALU with optional fault injection.
    always_comb begin
        bench_r = ref_alu(alu_a, alu_b, alu_alucont);
        if (stuck1)  bench_r[0] = 1'b1;
        if (corrupt) bench_r = ~bench_r;
    end
    assign alu_result = bench_r;
    assign alu_zero   = (bench_r == 32'h0);

    task automatic apply_reset();
        cpu_req = 1'b0; test_en = 1'b1; stuck1 = 1'b0; corrupt = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        g = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; test_en = 1'b1; cpu_req = 1'b0;
        cpu_a = 32'h1234_5678; cpu_b = 32'h0BAD_F00D; cpu_alucont = 3'b110;
        @(posedge clk); #2;
        checks++; if (test_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", test_busy); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", burst_done); end
        checks++; if (fault_count !== 8'h0 || fault_alarm !== 1'b0) begin
            errors++; $display("FAIL reset_fault got=%0d/%b want=0/0", fault_count, fault_alarm); end
        checks++; if (first_fail_op !== 3'b0 || first_fail_a !== 32'h0) begin
            errors++; $display("FAIL reset_capture got=%h/%h want=0/0", first_fail_op, first_fail_a); end
        checks++; if (alu_a !== 32'h1234_5678 || alu_b !== 32'h0BAD_F00D || alu_alucont !== 3'b110) begin
            errors++; $display("FAIL reset_mux got=%h/%h/%h want=12345678/0badf00d/6", alu_a, alu_b, alu_alucont); end
        reset = 1'b0;
        g = 0;
    endtask

    task automatic test_first_burst();
        logic [31:0] tbl_res [5];
        logic        tbl_zero [5];
        tbl_res  = '{32'h0, 32'h0001_0001, 32'h0001_0001, 32'hFFFF_0001, 32'h1};
        tbl_zero = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            checks++; if (test_busy !== 1'b0) begin errors++; $display("FAIL startup_gap c=%0d got=%b want=0", c, test_busy); end
            @(posedge clk); #2;
        end
        for (int v = 0; v < NUM_VECTORS; v++) begin
            checks++; if (test_busy !== 1'b1 || alu_a !== lfsr_at(v / 5) || alu_b !== swap_half(lfsr_at(v / 5))
                          || alu_alucont !== op_at(v) || burst_done !== 1'b0) begin
                errors++; $display("FAIL burst_vec v=%0d got=%b %h %h %h want=1 %h %h %h", v, test_busy, alu_a, alu_b,
                                   alu_alucont, lfsr_at(v / 5), swap_half(lfsr_at(v / 5)), op_at(v)); end
            if (v < 5) begin
                checks++; if (alu_a !== 32'h1 || alu_b !== 32'h0001_0000 || gold_res !== tbl_res[v] || gold_zero !== tbl_zero[v]) begin
                    errors++; $display("FAIL first_vec v=%0d got=%h %h res=%h z=%b want=1 10000 res=%h z=%b", v, alu_a, alu_b,
                                       gold_res, gold_zero, tbl_res[v], tbl_zero[v]); end
            end
            @(posedge clk); #2;
            g++;
        end
        checks++; if (burst_done !== 1'b1 || test_busy !== 1'b0 || fault_count !== 8'h0) begin
            errors++; $display("FAIL burst_end got done=%b busy=%b fc=%0d want 1 0 0", burst_done, test_busy, fault_count); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            checks++; if (test_busy !== 1'b0 || burst_done !== 1'b0) begin
                errors++; $display("FAIL burst_gap c=%0d got busy=%b done=%b want 0 0", c, test_busy, burst_done); end
        end
        @(posedge clk); #2;
        checks++; if (test_busy !== 1'b1 || alu_a !== lfsr_at(4) || alu_alucont !== 3'b000) begin
            errors++; $display("FAIL next_burst got=%b %h %h want=1 %h 0", test_busy, alu_a, alu_alucont, lfsr_at(4)); end
    endtask

    task automatic test_preempt();
        apply_reset();
        repeat (4) begin @(posedge clk); #2; end
        for (int v = 0; v < 7; v++) begin
            checks++; if (test_busy !== 1'b1 || alu_a !== lfsr_at(v / 5) || alu_alucont !== op_at(v)) begin
                errors++; $display("FAIL pre_vec v=%0d got=%b %h %h", v, test_busy, alu_a, alu_alucont); end
            @(posedge clk); #2;
        end
        cpu_req = 1'b1; cpu_a = 32'd5; cpu_b = 32'd3; cpu_alucont = 3'b010;
        #1;
        checks++; if (test_busy !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_alucont !== 3'b010) begin
            errors++; $display("FAIL preempt_mux got=%b %h %h %h want=0 5 3 2", test_busy, alu_a, alu_b, alu_alucont); end
        @(posedge clk); #1; cpu_req = 1'b0; #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (test_busy !== 1'b0) begin errors++; $display("FAIL preempt_gap c=%0d got=%b want=0", c, test_busy); end
            @(posedge clk); #1;
            if (c == 3) begin cpu_req = 1'b1; cpu_a = 32'hA5A5_0000; end
            #1;
        end
        // TEST was entered on the last edge, but the CPU grabbed the ALU right away.
        checks++; if (test_busy !== 1'b0 || alu_a !== 32'hA5A5_0000) begin
            errors++; $display("FAIL boundary_mux got=%b %h want=0 a5a50000", test_busy, alu_a); end
        @(posedge clk); #1; cpu_req = 1'b0; #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (test_busy !== 1'b0) begin errors++; $display("FAIL boundary_gap c=%0d got=%b want=0", c, test_busy); end
            @(posedge clk); #2;
        end
        g = 7;
        for (int v = 7; v < NUM_VECTORS; v++) begin
            checks++; if (test_busy !== 1'b1 || alu_a !== lfsr_at(v / 5) || alu_b !== swap_half(lfsr_at(v / 5))
                          || alu_alucont !== op_at(v)) begin
                errors++; $display("FAIL resume_vec v=%0d got=%b %h %h want=1 %h %h", v, test_busy, alu_a, alu_alucont,
                                   lfsr_at(v / 5), op_at(v)); end
            @(posedge clk); #2;
        end
        checks++; if (burst_done !== 1'b1 || fault_count !== 8'h0) begin
            errors++; $display("FAIL resume_done got done=%b fc=%0d want 1 0", burst_done, fault_count); end
    endtask

    task automatic test_fault();
        apply_reset();
        repeat (4) begin @(posedge clk); #2; end
        stuck1 = 1'b1;
        #1;
        checks++; if (test_busy !== 1'b1 || alu_alucont !== 3'b000 || alu_result !== 32'h1) begin
            errors++; $display("FAIL inject_setup got=%b op=%h res=%h want=1 0 1", test_busy, alu_alucont, alu_result); end
        @(posedge clk); #1; stuck1 = 1'b0; #1;
        checks++; if (fault_count !== 8'd1 || fault_alarm !== 1'b1 || first_fail_op !== 3'b000 || first_fail_a !== 32'h1) begin
            errors++; $display("FAIL inject got fc=%0d al=%b op=%h a=%h want 1 1 0 1", fault_count, fault_alarm,
                               first_fail_op, first_fail_a); end
        repeat (4) begin @(posedge clk); #2; end
        checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL inject_hold got=%0d want=1", fault_count); end
    endtask

    task automatic test_saturation();
        int cmp = 0;
        int cyc = 0;
        corrupt = 1'b1;
        #1;
        while (cmp < 300 && cyc < 3000) begin
            if (test_busy) cmp++;
            @(posedge clk); #2;
            cyc++;
            if (cmp == 100 && test_busy) begin
                checks++; if (fault_count !== 8'd101) begin errors++; $display("FAIL sat_mid got=%0d want=101", fault_count); end
            end
        end
        corrupt = 1'b0;
        checks++; if (cmp < 300) begin errors++; $display("FAIL sat_timeout compares=%0d want=300", cmp); end
        checks++; if (fault_count !== 8'd255 || fault_alarm !== 1'b1) begin
            errors++; $display("FAIL sat_count got=%0d al=%b want=255 1", fault_count, fault_alarm); end
        checks++; if (first_fail_op !== 3'b000 || first_fail_a !== 32'h1) begin
            errors++; $display("FAIL sat_capture got=%h %h want=0 1", first_fail_op, first_fail_a); end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        while (!test_busy && cyc < 40) begin @(posedge clk); #2; cyc++; end
        checks++; if (test_busy !== 1'b1) begin errors++; $display("FAIL areset_wait got=%b want=1", test_busy); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (fault_count !== 8'h0 || fault_alarm !== 1'b0 || first_fail_a !== 32'h0 || test_busy !== 1'b0
                      || burst_done !== 1'b0 || first_fail_op !== 3'b0) begin
            errors++; $display("FAIL areset got fc=%0d al=%b a=%h busy=%b want all 0", fault_count, fault_alarm,
                               first_fail_a, test_busy); end
        @(posedge clk); #1; reset = 1'b0; #1;
        g = 0;
        repeat (4) begin @(posedge clk); #2; end
        checks++; if (test_busy !== 1'b1 || alu_a !== 32'h1 || alu_alucont !== 3'b000) begin
            errors++; $display("FAIL areset_lfsr got=%b %h %h want=1 1 0", test_busy, alu_a, alu_alucont); end
    endtask

    task automatic test_random();
        int  quiet = 0;
        logic exp_done = 1'b0;
        logic exp_busy;
        logic idle;
        int  bad = 0;
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            cpu_req     = ($urandom_range(0, 99) < 20);
            test_en     = ($urandom_range(0, 99) < 95);
            cpu_a       = $urandom;
            cpu_b       = $urandom;
            cpu_alucont = 3'($urandom_range(0, 7));
            #1;
            idle     = !cpu_req && test_en;
            exp_busy = idle && (quiet >= IDLE_THRESH);
            checks++;
            if (test_busy !== exp_busy || burst_done !== exp_done || fault_count !== 8'h0
                || (exp_busy && (alu_a !== lfsr_at(g / 5) || alu_b !== swap_half(lfsr_at(g / 5)) || alu_alucont !== op_at(g)))
                || (!exp_busy && (alu_a !== cpu_a || alu_b !== cpu_b || alu_alucont !== cpu_alucont))) begin
                errors++;
                if (bad < 5) $display("FAIL random cyc=%0d got busy=%b done=%b a=%h op=%h want busy=%b done=%b g=%0d",
                                      cyc, test_busy, burst_done, alu_a, alu_alucont, exp_busy, exp_done, g);
                bad++;
            end
            exp_done = exp_busy && (g % NUM_VECTORS == NUM_VECTORS - 1);
            if (exp_busy) g++;
            if (!idle || exp_done) quiet = 0;
            else quiet++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_preempt();
        test_fault();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_selftest_sched.md
Name: alu_selftest_sched

Overview:
- Shares the processor ALU between the CPU datapath and a background self-test engine.
- The CPU always has priority. After IDLE_THRESH consecutive cycles without a CPU request, the block drives pseudo-random test vectors into the ALU and checks each result against an internal golden model.
- It counts mismatches and raises a sticky alarm, so the ALU's internal masking can be supplemented by system-level fault reporting.
- Sits between the datapath operand/control muxes and the ALU.

Parameters:
- IDLE_THRESH, 4: consecutive idle cycles required before test issue starts (≥1).
- NUM_VECTORS, 20: compares per burst (≥1).
- FAULT_LIMIT, 1: fault_count value at which fault_alarm asserts (1..255).
- LFSR_SEED, 32'h00000001: LFSR reset value (non-zero).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- test_en  in  1  allows self-test; 0 forces IDLE
- cpu_req  in  1  CPU is using the ALU this cycle
- cpu_a  in  32  CPU operand a
- cpu_b  in  32  CPU operand b
- cpu_alucont  in  3  CPU ALU control
- alu_a  out  32  operand a to ALU
- alu_b  out  32  operand b to ALU
- alu_alucont  out  3  control to ALU
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- test_busy  out  1  ALU currently carries a test vector
- burst_done  out  1  one-cycle pulse when a burst completes
- fault_count  out  8  saturating mismatch count
- fault_alarm  out  1  sticky; set when fault_count ≥ FAULT_LIMIT
- first_fail_op  out  3  alucont of the first failing vector
- first_fail_a  out  32  operand a of the first failing vector

Behaviour:
- Reset is asynchronous and active-high on clk domain; "reset reset, asynchronous, active-high; clock clk".
- Reset values:
  - state=IDLE; idle_cnt=0; vec_cnt=0; op_idx=0; lfsr=LFSR_SEED.
  - fault_count=0; fault_alarm=0; first_fail_op=0; first_fail_a=0; burst_done=0.
- Output mux (combinational):
  - When test_busy=1, alu_* carry the test vector; otherwise they carry cpu_*.
  - test_busy = (state==TEST) & ~cpu_req & test_en.
  - The CPU therefore never stalls and preempts a test vector in the same cycle.
- State machine:
  - IDLE: idle_cnt counts cycles with cpu_req=0 & test_en=1. Any cpu_req or ~test_en clears idle_cnt. When idle_cnt reaches IDLE_THRESH-1 on an idle cycle, go to TEST next cycle.
  - TEST: every cycle with test_busy=1 is a compare cycle. cpu_req or ~test_en → IDLE and clear idle_cnt; the vector is not compared. vec_cnt, op_idx and lfsr are retained, so the burst resumes at the same vector.
  - TEST, last vector: on a compare cycle with vec_cnt==NUM_VECTORS-1, go to IDLE, clear vec_cnt and idle_cnt, and pulse burst_done next cycle.
- Vector generation:
  - op sequence by op_idx 0..4: 3'b000, 001, 010, 110, 111.
  - Test operands: a=lfsr, b={lfsr[15:0],lfsr[31:16]}.
  - On each compare cycle, op_idx increments. On wrap 4→0, the LFSR steps once (Galois, taps x^32+x^22+x^2+x+1, i.e. mask 32'h80200003, shift right), so each operand pair sees all five ops.
  - op_idx and lfsr persist across bursts.
- Golden model (combinational):
  - AND: a&b. OR: a|b. ADD: a+b (mod 2^32).
  - SUB (110): a-b. SLT (111): {31'b0, (a-b)[31]}.
  - Expected zero = (golden==0).
- Compare:
  - mismatch = compare cycle & ((alu_result≠golden) | (alu_zero≠golden_zero)).
  - Mismatch effects appear registered the next cycle: fault_count += 1, saturating at 255.
  - If fault_count was 0 before the mismatch, capture first_fail_op and first_fail_a.
  - fault_alarm sets when the updated count ≥ FAULT_LIMIT and clears only on reset.
- Boundaries:
  - cpu_req rising in the same cycle as the IDLE→TEST transition: TEST entered, but test_busy=0, so TEST immediately returns to IDLE.
  - Reset mid-burst: all state returns to reset values, including lfsr.

Decomposition:
- Shared package: ALU op codes (ALU_AND=3'b000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111), state encoding, LFSR tap mask.
- Sub-module alu_golden: combinational golden result and zero for a, b, alucont; reusable by benches.

Test Plan:
- Reset, test_en=1, cpu_req=0:
  - test_busy rises on cycle 4 after reset release.
  - First compares drive a=0x00000001, b=0x00010000.
  - Expected results are op000→0 (zero=1), op001→0x00010001, op010→0x00010001, op110→0xFFFF0001, op111→0x00000001.
  - Fault-free ALU model: fault_count stays 0.
- Full burst: after 20 compare cycles, burst_done pulses once and test_busy drops. The next burst starts 4 idle cycles later with op_idx=0 and the LFSR stepped 4 times.
- Preemption:
  - Assert cpu_req=1 with cpu_a=5, cpu_b=3, cpu_alucont=010 during test vector 7: alu_a=5, alu_b=3 in the same cycle and no compare occurs.
  - After release plus 4 idle cycles, the burst resumes at vector 7.
- Injected fault: force alu_result[0] stuck-at-1 on the AND compare of vector 0 → fault_count=1 next cycle, fault_alarm=1, first_fail_op=000, first_fail_a=0x00000001.
- Saturation: permanent mismatch for 300 compares → fault_count holds 255. Capture registers retain the first failure.
- Asynchronous reset asserted mid-burst with fault_alarm=1: all outputs return to reset values immediately, without waiting for a clock edge.
